// File: rtl/im_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package im_pkg;

    localparam int unsigned IM_DEPTH   = 4096;
    localparam int unsigned IM_AW      = 12;
    localparam logic [31:0] IM_BASE_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/im_wr_port.sv
// Registered IM write stage: one strobe cycle per accepted word, cancelled by reset.
module im_wr_port
    import im_pkg::*;
#(
    parameter int unsigned AW      = IM_AW,
    parameter logic [31:0] BASE_PC = IM_BASE_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [31:0]   wr_pc
);

    logic [31:0] byte_off;

    assign byte_off = {{(30-AW){1'b0}}, addr, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_pc   <= BASE_PC;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= data;
                wr_pc   <= BASE_PC + byte_off;
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: streams words into the IM and holds the CPU in reset until done.
// Optional build macro IM_LOADER_CHECKSUM_EN adds chk_sum/exp_sum verification.
module im_loader
    import im_pkg::*;
#(
    parameter int unsigned DEPTH   = IM_DEPTH,
    parameter int unsigned AW      = IM_AW,
    parameter logic [31:0] BASE_PC = IM_BASE_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [31:0]   wr_pc,
    output logic [AW:0]   word_count,
`ifdef IM_LOADER_CHECKSUM_EN
    input  logic [31:0]   exp_sum,
    output logic [31:0]   chk_sum,
`endif
    output logic          load_done,
    output logic          load_err,
    output logic          cpu_hold
);

    ld_state_t     state;
    ld_state_t     state_next;
    logic [AW-1:0] idx;
    logic          accept;
    logic          restart;
    logic          at_last_slot;
    logic          sum_ok;

    assign accept       = in_valid && in_ready;
    assign restart      = start && (state != LOAD);
    assign at_last_slot = (idx == AW'(DEPTH - 1));

`ifdef IM_LOADER_CHECKSUM_EN
    // The final word is folded in combinationally so the compare happens on the in_last edge.
    assign sum_ok = ((chk_sum + in_data) == exp_sum);
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = sum_ok ? DONE : ERR;
                    end else if (at_last_slot) begin
                        state_next = ERR;
                    end
                end
            end
            DONE: if (start) state_next = LOAD;
            ERR:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        load_done = (state == DONE);
        load_err  = (state == ERR);
        cpu_hold  = (state != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            word_count <= '0;
        end else if (restart) begin
            idx        <= '0;
            word_count <= '0;
        end else if (accept) begin
            if (!at_last_slot) begin
                idx <= idx + 1'b1;
            end
            if (word_count != (AW+1)'(DEPTH)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_sum <= '0;
        end else if (restart) begin
            chk_sum <= '0;
        end else if (accept) begin
            chk_sum <= chk_sum + in_data;
        end
    end
`endif

    im_wr_port #(
        .AW      (AW),
        .BASE_PC (BASE_PC)
    ) u_wr_port (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .addr    (idx),
        .data    (in_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_pc   (wr_pc)
    );

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the 4096-word instruction memory. The CPU fetch path only reads the IM; this block is what fills it.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word slots. Word index 0 corresponds to PC 0x0000_3000.
- Holds the CPU in reset until loading finishes.
- Sits between the host/testbench stream source and the write port of a RAM-based IM.

Parameters:
- DEPTH, 4096, number of IM words; must be a power of two.
- AW, 12, word-address width, equal to log2(DEPTH).
- BASE_PC, 32'h0000_3000, byte address of word 0; used only for the wr_pc output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load from word 0.
- in_valid  in  1  source has a word on in_data.
- in_data  in  32  instruction word.
- in_last  in  1  qualifies in_data as the final word of the program.
- in_ready  out  1  loader can accept a word this cycle.
- wr_en  out  1  IM write strobe.
- wr_addr  out  AW  IM word index.
- wr_data  out  32  IM write data.
- wr_pc  out  32  BASE_PC + {wr_addr,2'b00}; for debug/trace only.
- word_count  out  AW+1  number of words written in the current or last load.
- load_done  out  1  level; program loaded successfully.
- load_err  out  1  level; overflow occurred.
- cpu_hold  out  1  level; drives CPU reset, high unless load_done.

Behaviour:
- States: IDLE, LOAD, DONE, ERR. reset forces IDLE asynchronously.
- Reset values of all outputs:
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_pc=BASE_PC, word_count=0.
  - load_done=0, load_err=0, cpu_hold=1.
- Handshake:
  - A word is accepted only on a clock edge where in_valid&&in_ready.
  - in_ready is combinational from state: it is 1 only in LOAD.
  - The source may hold in_valid high across cycles. Data may change only after acceptance.
- Write latency: a word accepted at edge N produces wr_en=1 for exactly the cycle after edge N. wr_addr, wr_data and wr_pc are registered at edge N; wr_en otherwise 0.
- IDLE:
  - start moves to LOAD, clears word_count, and clears the internal write index to 0.
- LOAD:
  - Each accepted word: wr_addr<=index, wr_data<=in_data, index++, word_count++.
  - in_last with acceptance moves to DONE at the same edge. The final write strobe still appears in the following cycle.
  - Acceptance of word index DEPTH-1 without in_last moves to ERR. That word is still written. Index does not wrap.
  - in_valid low: hold state, no write, no timeout.
- DONE:
  - load_done=1 and cpu_hold=0, both registered. They rise the cycle after the in_last acceptance edge, together with the final wr_en.
  - start returns to LOAD (re-load), dropping load_done and raising cpu_hold at that edge.
- ERR:
  - load_err=1, cpu_hold=1, in_ready=0.
  - start returns to LOAD and clears load_err.
- start in LOAD: ignored.
- start coincident with an acceptance: the acceptance proceeds and start is ignored.
- Reset mid-load: immediate return to IDLE.
  - IM contents already written are not cleared.
  - A pending wr_en is cancelled (forced to 0).
- Unwritten IM words keep prior contents; this block never zero-fills.
- word_count saturates at DEPTH. It holds its value in DONE/ERR until the next start.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output port chk_sum [31:0]: a 32-bit wraparound sum of all accepted words, cleared on start and on reset.
  - Extra input exp_sum [31:0], sampled when the state becomes DONE. If chk_sum != exp_sum, the block enters ERR instead of DONE (load_err=1, cpu_hold=1).
- Undefined: both ports are absent and DONE is entered unconditionally on in_last.

Decomposition:
- Shared package im_pkg:
  - IM_DEPTH=4096, IM_AW=12, IM_BASE_PC=32'h0000_3000.
  - State enum typedef ld_state_t {IDLE, LOAD, DONE, ERR}.
- Sub-module im_wr_port: the registered write stage (wr_en/wr_addr/wr_data/wr_pc, with cancel on reset). All FSM logic stays in im_loader.

Test Plan:
- Basic load: reset, start, stream 34010001, 00411020, 1041fffe, with in_last on word 3.
  - Expect wr_en at cycles N+1 with addr 0,1,2 and wr_pc 3000/3004/3008.
  - Expect load_done=1, cpu_hold=0, word_count=3.
- Back-pressure/gaps: in_valid toggled 1,0,0,1,1 across 3 words.
  - Expect exactly 3 writes, in order, with no duplicates and no writes while in_valid=0.
- Overflow: stream 4096 words with in_last never set.
  - Expect the write to addr 4095 occurs, then load_err=1, in_ready=0, cpu_hold=1, word_count=4096.
- Reset mid-load: assert reset after 2 accepted words, with the 2nd write pending.
  - Expect wr_en=0 immediately, state IDLE, cpu_hold=1, word_count=0.
- Re-load: after DONE, pulse start and stream 1 word 3c080001 with in_last.
  - Expect load_done drops then rises again, with the write at addr 0.
- With IM_LOADER_CHECKSUM_EN: stream words 1 and 2, exp_sum=3 → load_done. Repeat with exp_sum=4 → load_err=1.
